// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: bus widths, reset address,
// the NOP encoding and the fetch FSM state type.
package inst_fetch_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 32;

    localparam logic [INST_ADDR_W-1:0] PC_RST_ADDR = 32'h0000_0000;
    localparam logic [INST_W-1:0]      ZERO_WORD   = 32'h0000_0000;
    localparam logic [INST_W-1:0]      INST_NOP    = 32'h0000_0013;

    localparam logic [INST_ADDR_W-1:0] PC_STEP     = 32'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_OUT  = 2'd3
    } fetch_state_e;

    // Jump targets are always word aligned; the low two address bits are dropped.
    function automatic logic [INST_ADDR_W-1:0] alignAddr(input logic [INST_ADDR_W-1:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/inst_fetch.sv
// Instruction fetch unit: owns the fetch PC, issues one outstanding bus request
// and presents the fetched instruction (or a NOP bubble) to IF/ID.
// Optional bubble counter enabled with `define IFU_PERF_CNT_EN.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [INST_ADDR_W-1:0] RST_ADDR = PC_RST_ADDR,
    parameter logic [INST_W-1:0]      NOP_INST = INST_NOP
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   hold_i,
    input  logic                   jump_i,
    input  logic [INST_ADDR_W-1:0] jump_addr_i,
    output logic                   ibus_req_o,
    output logic [INST_ADDR_W-1:0] ibus_addr_o,
    input  logic                   ibus_gnt_i,
    input  logic                   ibus_rvalid_i,
    input  logic [INST_W-1:0]      ibus_rdata_i,
    output logic [INST_ADDR_W-1:0] pc_o,
    output logic [INST_W-1:0]      inst_o,
    output logic                   inst_valid_o
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]            bubble_cnt_o
`endif
);

    fetch_state_e           r_state;
    fetch_state_e           w_stateNext;
    logic [INST_ADDR_W-1:0] r_fetchPc;
    logic [INST_ADDR_W-1:0] w_fetchPcNext;
    logic [INST_ADDR_W-1:0] r_bufPc;
    logic [INST_ADDR_W-1:0] w_bufPcNext;
    logic [INST_W-1:0]      r_bufInst;
    logic [INST_W-1:0]      w_bufInstNext;
    logic                   r_bufV;
    logic                   w_bufVNext;
    logic                   r_kill;
    logic                   w_killNext;
    logic [INST_ADDR_W-1:0] w_target;

    assign w_target = alignAddr(jump_addr_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_fetchPc <= RST_ADDR;
            r_bufPc   <= RST_ADDR;
            r_bufInst <= ZERO_WORD;
            r_bufV    <= 1'b0;
            r_kill    <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_fetchPc <= w_fetchPcNext;
            r_bufPc   <= w_bufPcNext;
            r_bufInst <= w_bufInstNext;
            r_bufV    <= w_bufVNext;
            r_kill    <= w_killNext;
        end
    end

    // A granted fetch that is overtaken by a jump is marked killed so its data is drained, not used.
    always_comb begin
        w_stateNext   = r_state;
        w_fetchPcNext = r_fetchPc;
        w_bufPcNext   = r_bufPc;
        w_bufInstNext = r_bufInst;
        w_bufVNext    = r_bufV;
        w_killNext    = r_kill;
        case (r_state)
            ST_IDLE: begin
                w_stateNext = ST_REQ;
            end
            ST_REQ: begin
                if (jump_i) begin
                    w_fetchPcNext = w_target;
                end
                if (ibus_gnt_i) begin
                    w_stateNext = ST_WAIT;
                    if (jump_i) begin
                        w_killNext = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (ibus_rvalid_i) begin
                    if (r_kill || jump_i) begin
                        w_killNext  = 1'b0;
                        w_stateNext = ST_REQ;
                        if (jump_i) begin
                            w_fetchPcNext = w_target;
                        end
                    end else begin
                        w_bufInstNext = ibus_rdata_i;
                        w_bufPcNext   = r_fetchPc;
                        w_bufVNext    = 1'b1;
                        w_fetchPcNext = r_fetchPc + PC_STEP;
                        w_stateNext   = ST_OUT;
                    end
                end else if (jump_i) begin
                    w_fetchPcNext = w_target;
                    w_killNext    = 1'b1;
                end
            end
            ST_OUT: begin
                if (jump_i) begin
                    w_bufVNext    = 1'b0;
                    w_fetchPcNext = w_target;
                    w_stateNext   = ST_REQ;
                end else if (!hold_i) begin
                    w_bufVNext  = 1'b0;
                    w_stateNext = ST_REQ;
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    assign ibus_req_o   = (r_state == ST_REQ);
    assign ibus_addr_o  = r_fetchPc;
    assign pc_o         = r_bufPc;
    assign inst_o       = r_bufV ? r_bufInst : NOP_INST;
    assign inst_valid_o = r_bufV;

`ifdef IFU_PERF_CNT_EN
    logic [31:0] r_bubbleCnt;

    // Counts cycles in which IF/ID captures a bubble; sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bubbleCnt <= 32'd0;
        end else if (!hold_i && !r_bufV && (r_bubbleCnt != 32'hFFFF_FFFF)) begin
            r_bubbleCnt <= r_bubbleCnt + 32'd1;
        end
    end

    assign bubble_cnt_o = r_bubbleCnt;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios followed by randomized
// bus/stall/jump traffic, all checked against a transaction-level model.
module tb_inst_fetch;

    logic        clk;
    logic        rst_n;
    logic        hold_i;
    logic        jump_i;
    logic [31:0] jump_addr_i;
    logic        ibus_req_o;
    logic [31:0] ibus_addr_o;
    logic        ibus_gnt_i;
    logic        ibus_rvalid_i;
    logic [31:0] ibus_rdata_i;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        inst_valid_o;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] bubble_cnt_o;
`endif

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] DATA_KEY = 32'hA5A5_0000;

    inst_fetch dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .hold_i       (hold_i),
        .jump_i       (jump_i),
        .jump_addr_i  (jump_addr_i),
        .ibus_req_o   (ibus_req_o),
        .ibus_addr_o  (ibus_addr_o),
        .ibus_gnt_i   (ibus_gnt_i),
        .ibus_rvalid_i(ibus_rvalid_i),
        .ibus_rdata_i (ibus_rdata_i),
        .pc_o         (pc_o),
        .inst_o       (inst_o),
        .inst_valid_o (inst_valid_o)
`ifdef IFU_PERF_CNT_EN
        ,
        .bubble_cnt_o (bubble_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compareCount = 0;
    int failCount    = 0;

    // Transaction-level model: what the fetch unit is doing, not how it encodes it.
    bit          mStarting;
    bit          mRequesting;
    bit          mAwaiting;
    bit          mDiscard;
    bit          mHave;
    logic [31:0] mPc;
    logic [31:0] mBufPc;
    logic [31:0] mBufInst;
    logic [31:0] mBubbles;

    // Bus responder bookkeeping.
    bit          busPending;
    logic [31:0] busAddr;
    int          busDelay;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s at %0t: got %08h expected %08h", tag, $time, observed, expected);
        end
    endtask

    task automatic resetModel();
        mStarting   = 1'b1;
        mRequesting = 1'b0;
        mAwaiting   = 1'b0;
        mDiscard    = 1'b0;
        mHave       = 1'b0;
        mPc         = 32'h0;
        mBufPc      = 32'h0;
        mBufInst    = 32'h0;
        mBubbles    = 32'h0;
        busPending  = 1'b0;
        busAddr     = 32'h0;
        busDelay    = 0;
    endtask

    task automatic checkAll();
        checkOutput("req", {31'd0, ibus_req_o}, {31'd0, mRequesting});
        checkOutput("addr", ibus_addr_o, mPc);
        checkOutput("valid", {31'd0, inst_valid_o}, {31'd0, mHave});
        checkOutput("inst", inst_o, mHave ? mBufInst : NOP);
        checkOutput("pc", pc_o, mBufPc);
`ifdef IFU_PERF_CNT_EN
        checkOutput("bubbles", bubble_cnt_o, mBubbles);
`endif
    endtask

    task automatic modelStep(input bit h, input bit j, input logic [31:0] ja, input bit g, input bit rv,
                             input logic [31:0] rd);
        logic [31:0] tgt;
        tgt = {ja[31:2], 2'b00};
        if (!h && !mHave && mBubbles != 32'hFFFF_FFFF) mBubbles = mBubbles + 1;
        if (mStarting) begin
            mStarting   = 1'b0;
            mRequesting = 1'b1;
        end else if (mRequesting) begin
            if (j) mPc = tgt;
            if (g) begin
                mRequesting = 1'b0;
                mAwaiting   = 1'b1;
                mDiscard    = j;
            end
        end else if (mAwaiting) begin
            if (rv) begin
                mAwaiting = 1'b0;
                if (mDiscard || j) begin
                    mDiscard    = 1'b0;
                    mRequesting = 1'b1;
                    if (j) mPc = tgt;
                end else begin
                    mBufInst = rd;
                    mBufPc   = mPc;
                    mHave    = 1'b1;
                    mPc      = mPc + 32'd4;
                end
            end else if (j) begin
                mPc      = tgt;
                mDiscard = 1'b1;
            end
        end else if (mHave) begin
            if (j || !h) begin
                mHave       = 1'b0;
                mRequesting = 1'b1;
                if (j) mPc = tgt;
            end
        end
    endtask

    // Called at a falling edge: check, drive one cycle of inputs, advance model at the rising edge.
    task automatic applyStimulus(input bit h, input bit j, input logic [31:0] ja, input bit g,
                                 input int dly, input bit stray);
        bit rv;
        checkAll();
        rv = (busPending && busDelay == 0) || stray;
        hold_i        = h;
        jump_i        = j;
        jump_addr_i   = ja;
        ibus_gnt_i    = g;
        ibus_rvalid_i = rv;
        ibus_rdata_i  = (busPending && busDelay == 0) ? (busAddr ^ DATA_KEY) : $urandom;
        @(posedge clk);
        if (busPending) begin
            if (rv) busPending = 1'b0;
            else busDelay--;
        end
        if (mRequesting && g) begin
            busPending = 1'b1;
            busAddr    = mPc;
            busDelay   = dly;
        end
        modelStep(h, j, ja, g, rv, ibus_rdata_i);
        @(negedge clk);
    endtask

    task automatic doReset();
        #2 rst_n = 1'b0;
        resetModel();
        hold_i        = 1'b0;
        jump_i        = 1'b0;
        jump_addr_i   = 32'h0;
        ibus_gnt_i    = 1'b0;
        ibus_rvalid_i = 1'b0;
        ibus_rdata_i  = 32'h0;
        repeat (2) begin
            @(negedge clk);
            checkAll();
        end
        rst_n = 1'b1;
    endtask

    initial begin
        bit          did100;
        bit          did203;
        bit          didWrap;
        int          holdLeft;
        bit          h;
        bit          j;
        bit          g;
        logic [31:0] ja;
        int          pick;

        rst_n = 1'b0;
        @(negedge clk);
        doReset();

        // Directed: gnt every cycle, data one cycle later, hold at pc 0x8, jumps and wrap.
        did100   = 1'b0;
        did203   = 1'b0;
        didWrap  = 1'b0;
        holdLeft = 5;
        for (int c = 0; c < 90; c++) begin
            h  = 1'b0;
            j  = 1'b0;
            ja = 32'h0;
            if (mHave && mBufPc == 32'h8 && holdLeft > 0) begin
                h = 1'b1;
                holdLeft--;
            end
            if (mRequesting && mPc == 32'h10 && !did100) begin
                j      = 1'b1;
                ja     = 32'h100;
                did100 = 1'b1;
            end else if (mHave && did100 && !did203) begin
                h      = 1'b1;
                j      = 1'b1;
                ja     = 32'h203;
                did203 = 1'b1;
            end else if (did203 && mRequesting && mPc == 32'h200 && !didWrap) begin
                j       = 1'b1;
                ja      = 32'hFFFF_FFFE;
                didWrap = 1'b1;
            end
            applyStimulus(h, j, ja, 1'b1, 0, 1'b0);
        end

        // Directed: grant withheld for 10 cycles after reset, then a stray late rvalid.
        doReset();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 0, 1'b1);
        for (int c = 0; c < 9; c++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 0, 1'b0);
        for (int c = 0; c < 20; c++) applyStimulus(c > 4 && c < 12, 1'b0, 32'h0, 1'b1, 0, 1'b0);

        // Randomized traffic with one asynchronous reset in the middle.
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) begin
                doReset();
                applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 0, 1'b1);
            end
            h = ($urandom_range(0, 99) < 30);
            j = ($urandom_range(0, 99) < 8);
            g = ($urandom_range(0, 99) < 60);
            pick = $urandom_range(0, 3);
            case (pick)
                0:       ja = $urandom;
                1:       ja = 32'hFFFF_FFFC | $urandom_range(0, 3);
                default: ja = $urandom_range(0, 32'h3FF);
            endcase
            applyStimulus(h, j, ja, g, $urandom_range(0, 3), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
